// File: rtl/rst_seq_module.sv
// Reset sequencer: filters PLL lock, then releases staged active-low resets
// one at a time with a fixed spacing. Lock loss or a soft-reset request
// reasserts every stage.
//
// Optional feature macro: RST_SEQ_STATUS_EN (adds o_lock_loss_cnt).
//
// Ports:
//   i_clk            sole clock
//   i_rst_n          asynchronous active-low reset
//   i_pll_locked     PLL lock, asynchronous to i_clk (2-flop synchronized)
//   i_soft_rst       synchronous soft-reset request, honoured only in RUN
//   o_rst_n          staged active-low resets, bit 0 released first
//   o_ready          all stages released (RUN)
//   o_busy           sequencing in progress (FILTER, RELEASE, SOFT)
//   o_lock_loss_cnt  saturating count of lock losses after the filter
//                    (only with RST_SEQ_STATUS_EN)
module rst_seq_module #(
    parameter int unsigned P_STAGES      = 4,
    parameter int unsigned P_STAGE_DLY   = 16,
    parameter int unsigned P_LOCK_FILTER = 8,
    parameter int unsigned P_CNT_W       = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_pll_locked,
    input  logic                i_soft_rst,
    output logic [P_STAGES-1:0] o_rst_n,
    output logic                o_ready,
    output logic                o_busy
`ifdef RST_SEQ_STATUS_EN
    ,
    output logic [7:0]          o_lock_loss_cnt
`endif
);

    localparam int unsigned IDX_W = (P_STAGES > 1) ? $clog2(P_STAGES) : 1;
    localparam logic [P_CNT_W-1:0] DLY_LAST  = P_CNT_W'(P_STAGE_DLY - 1);
    localparam logic [P_CNT_W-1:0] FILT_LAST = P_CNT_W'(P_LOCK_FILTER - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(P_STAGES - 1);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_FILTER  = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_SOFT    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [P_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [P_STAGES-1:0]  rst_d;
    logic                 ready_d;
    logic                 busy_d;
    logic [1:0]           sync_q;
    logic                 locked_s;

    // Lock synchronizer; only locked_s is used for decisions.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            o_rst_n <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            o_rst_n <= rst_d;
            o_ready <= ready_d;
            o_busy  <= busy_d;
        end
    end

    // Next state, counters and next output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = o_rst_n;

        case (state_q)
            S_HOLD: begin
                rst_d = '0;
                if (locked_s) begin
                    state_d = S_FILTER;
                    cnt_d   = '0;
                end
            end

            S_FILTER: begin
                rst_d = '0;
                if (!locked_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + P_CNT_W'(1);
                end
            end

            S_RELEASE: begin
                if (!locked_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                end else if (cnt_q == DLY_LAST) begin
                    rst_d[idx_q] = 1'b1;
                    cnt_d        = '0;
                    // Last stage released: enter RUN on the same edge.
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + P_CNT_W'(1);
                end
            end

            S_RUN: begin
                rst_d = '1;
                // Lock loss takes priority over a soft-reset request.
                if (!locked_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                end else if (i_soft_rst) begin
                    state_d = S_SOFT;
                    cnt_d   = '0;
                    rst_d   = '0;
                end
            end

            S_SOFT: begin
                rst_d = '0;
                if (!locked_s) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == DLY_LAST) begin
                    // Lock is already qualified, so skip the filter.
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + P_CNT_W'(1);
                end
            end

            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
                rst_d   = '0;
            end
        endcase

        ready_d = (state_d == S_RUN);
        busy_d  = (state_d == S_FILTER) || (state_d == S_RELEASE) ||
                  (state_d == S_SOFT);
    end

`ifdef RST_SEQ_STATUS_EN
    // Lock losses after the filter has qualified lock; FILTER exits excluded.
    logic lock_loss_c;

    assign lock_loss_c = !locked_s &&
                         ((state_q == S_RELEASE) || (state_q == S_SOFT) ||
                          (state_q == S_RUN));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lock_loss_cnt <= 8'd0;
        end else if (lock_loss_c && (o_lock_loss_cnt != 8'hFF)) begin
            o_lock_loss_cnt <= o_lock_loss_cnt + 8'd1;
        end
    end
`else
    // No status counter in this build.
`endif

endmodule

// File: tb/tb_rst_seq_module.sv
// Self-checking bench for rst_seq_module: directed scenarios followed by
// randomized lock/soft-reset traffic, all checked against a timeline model.
module tb_rst_seq_module;

    localparam int P = 4;
    localparam int D = 16;
    localparam int F = 8;

    localparam int PH_HOLD = 0;
    localparam int PH_FILT = 1;
    localparam int PH_SEQ  = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_SOFT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pll_locked;
    logic         soft_rst;
    logic [P-1:0] rst_out;
    logic         ready;
    logic         busy;
`ifdef RST_SEQ_STATUS_EN
    logic [7:0]   loss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: phase plus the edge number at which it began.
    int m_ph;
    int m_cyc;
    int m_t0;
    bit m_s1;
    bit m_s2;
    int m_loss;

    always #5 clk = ~clk;

    rst_seq_module #(
        .P_STAGES     (P),
        .P_STAGE_DLY  (D),
        .P_LOCK_FILTER(F),
        .P_CNT_W      (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_pll_locked   (pll_locked),
        .i_soft_rst     (soft_rst),
        .o_rst_n        (rst_out),
        .o_ready        (ready),
        .o_busy         (busy)
`ifdef RST_SEQ_STATUS_EN
        ,
        .o_lock_loss_cnt(loss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph   = PH_HOLD;
        m_cyc  = 0;
        m_t0   = 0;
        m_s1   = 1'b0;
        m_s2   = 1'b0;
        m_loss = 0;
    endtask

    task automatic model_loss(input bool_counted);
        m_ph = PH_HOLD;
        if (bool_counted && m_loss < 255) m_loss++;
    endtask

    // One rising edge of the model, using inputs as sampled at that edge.
    task automatic model_edge();
        bit s;
        s = m_s2;
        m_cyc++;
        case (m_ph)
            PH_HOLD: if (s) begin m_ph = PH_FILT; m_t0 = m_cyc; end
            PH_FILT: begin
                if (!s) m_ph = PH_HOLD;
                else if (m_cyc - m_t0 == F) begin m_ph = PH_SEQ; m_t0 = m_cyc; end
            end
            PH_SEQ: begin
                if (!s) model_loss(1'b1);
                else if ((m_cyc - m_t0) / D >= P) m_ph = PH_RUN;
            end
            PH_RUN: begin
                if (!s) model_loss(1'b1);
                else if (soft_rst) begin m_ph = PH_SOFT; m_t0 = m_cyc; end
            end
            PH_SOFT: begin
                if (!s) model_loss(1'b1);
                else if (m_cyc - m_t0 == D) begin m_ph = PH_SEQ; m_t0 = m_cyc; end
            end
            default: m_ph = PH_HOLD;
        endcase
        m_s2 = m_s1;
        m_s1 = pll_locked;
    endtask

    function automatic int exp_rst();
        if (m_ph == PH_RUN) return (1 << P) - 1;
        if (m_ph == PH_SEQ) return (1 << ((m_cyc - m_t0) / D)) - 1;
        return 0;
    endfunction

    task automatic compare_all();
        check("rst_n", 32'(rst_out), 32'(exp_rst()));
        check("ready", 32'(ready), 32'(m_ph == PH_RUN));
        check("busy", 32'(busy), 32'(m_ph == PH_FILT || m_ph == PH_SEQ || m_ph == PH_SOFT));
`ifdef RST_SEQ_STATUS_EN
        check("loss_cnt", 32'(loss_cnt), 32'(m_loss));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rst_n", 32'(rst_out), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        soft_rst   = 1'b0;
        model_reset();
        apply_reset();

        // Short lock pulse inside the filter window returns to HOLD.
        pll_locked = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 5) pll_locked = 1'b0;
            if (e == 4) check("pulse_busy_hi", 32'(busy), 32'd1);
            if (e == 8) check("pulse_busy_lo", 32'(busy), 32'd0);
            if (e == 12) check("pulse_rst", 32'(rst_out), 32'd0);
        end

        // Full power-up sequence timing from the first locked edge.
        pll_locked = 1'b1;
        for (int e = 1; e <= 80; e++) begin
            step();
            if (e == 26) check("up_e26", 32'(rst_out), 32'h0);
            if (e == 27) check("up_e27", 32'(rst_out), 32'h1);
            if (e == 43) check("up_e43", 32'(rst_out), 32'h3);
            if (e == 59) check("up_e59", 32'(rst_out), 32'h7);
            if (e == 74) check("up_e74_ready", 32'(ready), 32'd0);
            if (e == 75) check("up_e75", 32'(rst_out), 32'hF);
            if (e == 75) check("up_e75_ready", 32'(ready), 32'd1);
        end

        // One-cycle soft reset from RUN.
        soft_rst = 1'b1;
        step();
        check("soft_e_rst", 32'(rst_out), 32'h0);
        check("soft_e_ready", 32'(ready), 32'd0);
        soft_rst = 1'b0;
        for (int k = 1; k <= 82; k++) begin
            step();
            if (k == 31) check("soft_e31", 32'(rst_out), 32'h0);
            if (k == 32) check("soft_e32", 32'(rst_out), 32'h1);
            if (k == 80) check("soft_e80", 32'(rst_out), 32'hF);
            if (k == 80) check("soft_e80_ready", 32'(ready), 32'd1);
        end

        // Lock loss and soft request together in RUN: HOLD wins.
        pll_locked = 1'b0;
        step();
        step();
        soft_rst = 1'b1;
        step();
        check("race_rst", 32'(rst_out), 32'h0);
        check("race_busy", 32'(busy), 32'd0);
        soft_rst = 1'b0;
        repeat (4) step();

        // Lock drop after two stages released.
        apply_reset();
        pll_locked = 1'b1;
        for (int e = 1; e <= 50; e++) step();
        pll_locked = 1'b0;
        step();
        step();
        check("drop_e52", 32'(rst_out), 32'h3);
        step();
        check("drop_e53", 32'(rst_out), 32'h0);
        check("drop_e53_busy", 32'(busy), 32'd0);
`ifdef RST_SEQ_STATUS_EN
        check("drop_loss_cnt", 32'(loss_cnt), 32'd1);
`endif
        repeat (3) step();

        // Asynchronous reset mid-RELEASE clears outputs without a clock edge.
        pll_locked = 1'b1;
        for (int e = 1; e <= 40; e++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'(rst_out), 32'h0);
        check("async_busy", 32'(busy), 32'd0);
`ifdef RST_SEQ_STATUS_EN
        check("async_loss_cnt", 32'(loss_cnt), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized lock / soft-reset traffic.
        for (int it = 0; it < 40; it++) begin
            int hi_len;
            int lo_len;
            hi_len = int'($urandom_range(1, 150));
            lo_len = int'($urandom_range(1, 8));
            pll_locked = 1'b1;
            for (int c = 0; c < hi_len; c++) begin
                soft_rst = ($urandom_range(0, 29) == 0);
                step();
            end
            soft_rst = 1'b0;
            pll_locked = 1'b0;
            for (int c = 0; c < lo_len; c++) begin
                soft_rst = ($urandom_range(0, 3) == 0);
                step();
            end
            soft_rst = 1'b0;
            if ($urandom_range(0, 9) == 0) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
